data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/types_pkg.sv | 30 +++
 rtl/dmem_array.sv | 24 ++
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/types_pkg.sv
// Shared types for the data memory responder: request record, FSM states
// and the access-legality check used by both the response path and the write path.
package types_pkg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic              wr;
        logic              is_byte;
        logic [15:0]       addr;
        logic [DATA_W-1:0] wdata;
    } memop_t;

    // Word index is addr[15:1]; word accesses must also be halfword aligned.
    function automatic logic access_err(input memop_t op, input int depth);
        logic [31:0] idx;
        logic [31:0] lim;
        idx = {17'd0, op.addr[15:1]};
        lim = depth;
        return (idx >= lim) || (!op.is_byte && op.addr[0]);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Data storage for the responder: synchronous write with one enable per
// byte lane, combinational read.
module dmem_array #(
    parameter int  DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic [1:0]    we,
    input  logic [AW-1:0] waddr,
    input  logic [15:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we[0]) mem[waddr][7:0]  <= wdata[7:0];
        if (we[1]) mem[waddr][15:8] <= wdata[15:8];
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder with a fixed number of wait states per request.
// Byte accesses are honoured only when DMEM_BYTE_EN is defined.
//
// state   | meaning
// IDLE    | ready for a request unless halt_sys is high
// WAIT    | request captured, wait counter running down
// RESP    | resp_valid high for one cycle; stores commit at the end of it
module data_mem_responder
    import types_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt_sys,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    fsm_state_t        state;
    logic [CNT_W-1:0]  cnt;
    memop_t            req_q;
    memop_t            req_in;
    memop_t            req_cur;
    logic              eff_byte;
    logic              accept;
    logic [15:0]       arr_rdata;
    logic [15:0]       arr_wdata;
    logic [1:0]        arr_we;
    logic              cur_err;
    logic [15:0]       cur_rdata;

`ifdef DMEM_BYTE_EN
    assign eff_byte = req_byte;
`else
    logic unused_req_byte;
    assign unused_req_byte = req_byte;
    assign eff_byte        = 1'b0;
`endif

    assign req_in    = '{wr: req_wr, is_byte: eff_byte, addr: req_addr, wdata: req_wdata};
    assign req_ready = (state == ST_IDLE) && !halt_sys;
    assign accept    = req_valid && req_ready;

    // With zero wait states the response is formed from the live request.
    assign req_cur = (state == ST_IDLE) ? req_in : req_q;

    function automatic logic [15:0] load_data(input memop_t op, input logic [15:0] word);
        if (op.wr)
            return 16'h0000;
        if (op.is_byte)
            return op.addr[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]};
        return word;
    endfunction

    assign cur_err   = access_err(req_cur, DEPTH);
    assign cur_rdata = cur_err ? 16'h0000 : load_data(req_cur, arr_rdata);

    always_comb begin
        arr_we = 2'b00;
        if (state == ST_RESP && req_q.wr && !access_err(req_q, DEPTH)) begin
            if (!req_q.is_byte)
                arr_we = 2'b11;
            else
                arr_we = req_q.addr[0] ? 2'b10 : 2'b01;
        end
    end

    assign arr_wdata = req_q.is_byte ? {2{req_q.wdata[7:0]}} : req_q.wdata;

    dmem_array #(.DEPTH(DEPTH)) u_array (
        .clk   (clk),
        .we    (arr_we),
        .waddr (req_q.addr[AW:1]),
        .wdata (arr_wdata),
        .raddr (req_cur.addr[AW:1]),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_q <= req_in;
                        cnt   <= CNT_W'(LATENCY);
                        busy  <= 1'b1;
                        if (LATENCY == 0) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= cur_rdata;
                            resp_err   <= cur_err;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= cur_rdata;
                        resp_err   <= cur_err;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance driven from a
// vector table plus hand sequences, and a LATENCY=0 instance for the halt case.
module tb_data_mem_responder;

`ifdef DMEM_BYTE_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        halt_sys = 1'b0, req_valid = 1'b0, req_wr = 1'b0, req_byte = 1'b0;
    logic [15:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [15:0] resp_rdata;

    logic        halt0 = 1'b0, valid0 = 1'b0, wr0 = 1'b0, byte0 = 1'b0;
    logic [15:0] addr0 = '0, wdata0 = '0;
    logic        ready0, rvalid0, rerr0, busy0;
    logic [15:0] rdata0;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst(rst), .halt_sys(halt_sys), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(0)) dut0 (
        .clk(clk), .rst(rst), .halt_sys(halt0), .req_valid(valid0), .req_ready(ready0),
        .req_wr(wr0), .req_byte(byte0), .req_addr(addr0), .req_wdata(wdata0),
        .resp_valid(rvalid0), .resp_rdata(rdata0), .resp_err(rerr0), .busy(busy0)
    );

    typedef struct {
        logic        wr;
        logic        bt;
        logic [15:0] addr;
        logic [15:0] wd;
        logic [15:0] exp_rd;
        logic        exp_err;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issue one request to the LATENCY=2 instance; lat counts cycles from the
    // accepting edge to the cycle where resp_valid is seen (-1 if never).
    task automatic issue(input logic wr, input logic bt, input logic [15:0] addr,
                         input logic [15:0] wd, output int lat,
                         output logic [15:0] rd, output logic er);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_byte = bt; req_addr = addr; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = -1; rd = '0; er = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; rd = resp_rdata; er = resp_err;
                break;
            end
        end
    endtask

    initial begin
        int          lat, rem, acc, rsp, seen;
        logic [15:0] rd;
        logic        er;

        tbl[0]  = '{1'b1, 1'b0, 16'h0000, 16'h0F0F, 16'h0000, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0002, 16'h7777, 16'h0000, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 16'h0011, 16'h005A, 16'h0000, !BE};
        tbl[5]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, BE ? 16'h5AEF : 16'hBEEF, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 16'h0010, 16'h0000, BE ? 16'h00EF : 16'hBEEF, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 16'h0011, 16'h0000, BE ? 16'h005A : 16'h0000, !BE};
        tbl[8]  = '{1'b0, 1'b0, 16'h0200, 16'h0000, 16'h0000, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 16'h0200, 16'h1234, 16'h0000, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 16'h0003, 16'h1111, 16'h0000, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 16'h0002, 16'h0000, 16'h7777, 1'b0};
        tbl[14] = '{1'b1, 1'b0, 16'h01FE, 16'hCAFE, 16'h0000, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 16'h01FE, 16'h0000, 16'hCAFE, 1'b0};
        tbl[16] = '{1'b1, 1'b1, 16'h0000, 16'hAB33, 16'h0000, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, 16'h0000, BE ? 16'h0F33 : 16'hAB33, 1'b0};
        tbl[18] = '{1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
        tbl[19] = '{1'b1, 1'b0, 16'h0020, 16'h1357, 16'h0000, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 16'h0010, 16'h0000, BE ? 16'h5AEF : 16'hBEEF, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst resp_valid", 16'(resp_valid), 16'h0);
        chk("rst busy",       16'(busy),       16'h0);
        chk("rst rdata",      resp_rdata,      16'h0000);
        chk("rst err",        16'(resp_err),   16'h0);
        chk("rst ready",      16'(req_ready),  16'h1);
        chk("rst busy0",      16'(busy0),      16'h0);
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            issue(tbl[i].wr, tbl[i].bt, tbl[i].addr, tbl[i].wd, lat, rd, er);
            chk_int($sformatf("v%0d latency", i), lat, 3);
            chk($sformatf("v%0d rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("v%0d err", i), 16'(er), 16'(tbl[i].exp_err));
        end

        // req_valid held high: accept only in IDLE, one response per accept
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_byte = 1'b0; req_addr = 16'h0002;
        rem = 0; acc = 0; rsp = 0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("hold c%0d busy", i),  16'(busy),       16'(rem != 0));
            chk($sformatf("hold c%0d ready", i), 16'(req_ready),  16'(rem == 0));
            chk($sformatf("hold c%0d resp", i),  16'(resp_valid), 16'(rem == 1));
            if (req_ready) acc++;
            if (resp_valid) begin
                rsp++;
                chk($sformatf("hold c%0d rdata", i), resp_rdata, 16'h7777);
            end
            rem = (rem == 0) ? 3 : rem - 1;
        end
        req_valid = 1'b0;
        chk_int("hold accepts", acc, 4);
        chk_int("hold responses", rsp, 4);

        // halt_sys rising in WAIT does not abort the request
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_byte = 1'b0; req_addr = 16'h0002;
        @(posedge clk);
        #1 req_valid = 1'b0;
        halt_sys = 1'b1;
        lat = -1; rd = '0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = i; rd = resp_rdata;
                break;
            end
        end
        chk_int("halt-in-wait latency", lat, 3);
        chk("halt-in-wait rdata", rd, 16'h7777);
        @(negedge clk);
        chk("halted ready", 16'(req_ready), 16'h0);
        halt_sys = 1'b0;
        @(negedge clk);
        chk("released ready", 16'(req_ready), 16'h1);

        // Reset during the WAIT of a store aborts it
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h2468;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort busy before rst", 16'(busy), 16'h1);
        rst = 1'b0;
        @(negedge clk);
        chk("abort busy", 16'(busy), 16'h0);
        chk("abort resp", 16'(resp_valid), 16'h0);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk_int("abort no resp", seen, 0);
        issue(1'b0, 1'b0, 16'h0020, 16'h0000, lat, rd, er);
        chk("abort old value", rd, 16'h1357);
        chk_int("abort load latency", lat, 3);

        // LATENCY=0 instance: store, then a load held off by halt_sys
        @(negedge clk);
        valid0 = 1'b1; wr0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'h4242;
        @(posedge clk);
        #1 valid0 = 1'b0;
        @(negedge clk);
        chk("l0 store resp", 16'(rvalid0), 16'h1);
        halt0 = 1'b1; valid0 = 1'b1; wr0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("l0 halted ready c%0d", i), 16'(ready0), 16'h0);
            chk($sformatf("l0 halted resp c%0d", i), 16'(rvalid0), 16'h0);
        end
        halt0 = 1'b0;
        #1 chk("l0 released ready", 16'(ready0), 16'h1);
        @(posedge clk);
        #1 valid0 = 1'b0;
        @(negedge clk);
        chk("l0 load resp", 16'(rvalid0), 16'h1);
        chk("l0 load rdata", rdata0, 16'h4242);
        chk("l0 load busy", 16'(busy0), 16'h1);
        @(negedge clk);
        chk("l0 single pulse", 16'(rvalid0), 16'h0);
        chk("l0 rdata cleared", rdata0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
